// File: rtl/vga_raster_gen.sv
// vga_raster_gen: raster timing source for the display path.
// Produces pixel coordinates, active-low syncs, display enable, a per-frame
// tick and a frame counter, all advancing on a divided pixel strobe.
// Optional feature macro: RASTER_ALIGN_EN -- delays hsync_n/vsync_n/inDisplay
// by PIPE_DEPTH clk cycles to line them up with twice-registered RGB.
module vga_raster_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_ce,
  output logic [9:0]  CounterX,
  output logic [9:0]  CounterY,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        inDisplay,
  output logic        frame_start,
  output logic [15:0] FrameCount
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

`ifdef RASTER_ALIGN_EN
  localparam int unsigned SYNC_DELAY = PIPE_DEPTH;
`else
  localparam int unsigned SYNC_DELAY = PIPE_DEPTH * 0;
`endif

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic          pce_q, pce_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [15:0]   fc_q, fc_d;
  logic          tick;

  // Next-state: divider, raster position, frame tick; syncs/enable are
  // decoded from the *next* position so they register alongside it.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
    pce_d = tick;
    x_d   = x_q;
    y_d   = y_q;
    fs_d  = 1'b0;
    fc_d  = fc_q;
    if (tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;
          fc_d = fc_q + 16'd1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    hs_d = !((x_d >= HS_BEG) && (x_d <= HS_END));
    vs_d = !((y_d >= VS_BEG) && (y_d <= VS_END));
    de_d = (x_d < X_ACT) && (y_d < Y_ACT);
  end

  // Raster state register; reset drops straight to the idle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      pce_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
      fc_q  <= '0;
    end else begin
      div_q <= div_d;
      pce_q <= pce_d;
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      fs_q  <= fs_d;
      fc_q  <= fc_d;
    end
  end

  assign pix_ce      = pce_q;
  assign CounterX    = x_q;
  assign CounterY    = y_q;
  assign frame_start = fs_q;
  assign FrameCount  = fc_q;

  if (SYNC_DELAY == 0) begin : g_direct
    assign hsync_n   = hs_q;
    assign vsync_n   = vs_q;
    assign inDisplay = de_q;
  end else begin : g_align
    logic [SYNC_DELAY-1:0] hs_pipe_q, vs_pipe_q, de_pipe_q;

    // Clk-rate delay line for syncs/enable only; coordinates stay undelayed.
    always_ff @(posedge clk) begin
      if (reset) begin
        hs_pipe_q <= '1;
        vs_pipe_q <= '1;
        de_pipe_q <= '0;
      end else begin
        hs_pipe_q[0] <= hs_q;
        vs_pipe_q[0] <= vs_q;
        de_pipe_q[0] <= de_q;
        for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
          hs_pipe_q[i] <= hs_pipe_q[i-1];
          vs_pipe_q[i] <= vs_pipe_q[i-1];
          de_pipe_q[i] <= de_pipe_q[i-1];
        end
      end
    end

    assign hsync_n   = hs_pipe_q[SYNC_DELAY-1];
    assign vsync_n   = vs_pipe_q[SYNC_DELAY-1];
    assign inDisplay = de_pipe_q[SYNC_DELAY-1];
  end

endmodule
